// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared constants, instruction fields and fetch-action type for the fetch stage
package fetch_stage_pkg;

  localparam int ISIZE_DEF    = 16;
  localparam int ASIZE_DEF    = 16;
  localparam int RESET_PC_DEF = 0;

  // ADD R0,R0,R0: harmless because R0 writes are dropped and never forwarded
  localparam logic [15:0] NOP = 16'h0000;

  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int RD_MSB     = 11;
  localparam int RD_LSB     = 8;
  localparam int RS_MSB     = 7;
  localparam int RS_LSB     = 4;
  localparam int RT_MSB     = 3;
  localparam int RT_LSB     = 0;

  typedef enum logic [1:0] {
    ACT_ADVANCE  = 2'd0,
    ACT_HOLD     = 2'd1,
    ACT_REDIRECT = 2'd2
  } fetch_act_e;

  function automatic fetch_act_e fetch_action(input logic redirect, input logic hold);
    if (redirect)  return ACT_REDIRECT;
    else if (hold) return ACT_HOLD;
    else           return ACT_ADVANCE;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory bus between the fetch stage and imem
interface fetch_stage_if #(
  parameter int ISIZE = 16,
  parameter int ASIZE = 16
);
  logic [ASIZE-1:0] imem_addr;
  logic [ISIZE-1:0] imem_rdata;

  modport master (output imem_addr, input  imem_rdata);
  modport slave  (input  imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_pc.sv
// rtl/fetch_pc.sv - program counter with reset/redirect/hold/increment priority and modulo wrap
module fetch_pc
  import fetch_stage_pkg::*;
#(
  parameter int          ASIZE    = ASIZE_DEF,
  parameter int unsigned RESET_PC = RESET_PC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  fetch_act_e       act,
  input  logic [ASIZE-1:0] redirect_pc,
  output logic [ASIZE-1:0] pc,
  output logic [ASIZE-1:0] pc_plus1
);

  localparam logic [ASIZE-1:0] RESET_VAL = ASIZE'(RESET_PC);

  // Natural width truncation gives the 2^ASIZE wrap
  assign pc_plus1 = pc + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc <= RESET_VAL;
    end else begin
      case (act)
        ACT_REDIRECT: pc <= redirect_pc;
        ACT_ADVANCE:  pc <= pc_plus1;
        default:      pc <= pc;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage and IF/ID register; FETCH_PERF_CNT_EN adds fetch/stall counters
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int          ISIZE    = ISIZE_DEF,
  parameter int          ASIZE    = ASIZE_DEF,
  parameter int unsigned RESET_PC = RESET_PC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  fetch_stage_if.master    imem,
  input  logic             hold,
  input  logic             redirect,
  input  logic [ASIZE-1:0] redirect_pc,
  input  logic             pcctrl,
  output logic [ISIZE-1:0] if_instr,
  output logic [ASIZE-1:0] if_pc_plus1,
  output logic             if_valid,
  output logic [ISIZE-1:0] last_instr,
  output logic             last_pcctrl
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]      perf_fetch,
  output logic [31:0]      perf_stall
`endif
);

  localparam logic [ISIZE-1:0] NOP_WORD = ISIZE'(NOP);

  fetch_act_e       act;
  logic [ASIZE-1:0] pc;
  logic [ASIZE-1:0] pc_plus1;

  assign act            = fetch_action(redirect, hold);
  assign imem.imem_addr = pc;

  fetch_pc #(
    .ASIZE    (ASIZE),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk         (clk),
    .rst         (rst),
    .act         (act),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .pc_plus1    (pc_plus1)
  );

  // if_pc_plus1 is left alone on redirect; if_valid=0 marks it as meaningless
  always_ff @(posedge clk) begin
    if (!rst) begin
      if_instr    <= NOP_WORD;
      if_pc_plus1 <= '0;
      if_valid    <= 1'b0;
      last_instr  <= NOP_WORD;
      last_pcctrl <= 1'b0;
    end else begin
      case (act)
        ACT_REDIRECT: begin
          if_instr    <= NOP_WORD;
          if_valid    <= 1'b0;
          last_instr  <= NOP_WORD;
          last_pcctrl <= 1'b0;
        end
        ACT_HOLD: begin
          last_instr  <= NOP_WORD;
          last_pcctrl <= 1'b0;
        end
        default: begin
          if_instr    <= imem.imem_rdata;
          if_pc_plus1 <= pc_plus1;
          if_valid    <= 1'b1;
          last_instr  <= if_instr;
          last_pcctrl <= pcctrl & if_valid;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetch <= '0;
      perf_stall <= '0;
    end else begin
      if (act == ACT_ADVANCE && perf_fetch != 32'hFFFF_FFFF) perf_fetch <= perf_fetch + 32'd1;
      if (act == ACT_HOLD    && perf_stall != 32'hFFFF_FFFF) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - table-driven scoreboard bench for fetch_stage
module tb_fetch_stage;

  typedef struct {
    logic        rst;
    logic        hold;
    logic        redir;
    logic        ovr;
    logic        pcctrl;
    logic [15:0] rpc;
    logic [15:0] addr;
    logic [15:0] instr;
    logic [15:0] pp1;
    logic        v;
    logic [15:0] last;
    logic        lpc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hold = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic        pcctrl = 1'b0;
  logic        ovr = 1'b0;
  logic [15:0] if_instr;
  logic [15:0] if_pc_plus1;
  logic        if_valid;
  logic [15:0] last_instr;
  logic        last_pcctrl;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_stall;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  vec_t tbl[$];
  vec_t sb[$];

  fetch_stage_if #(.ISIZE(16), .ASIZE(16)) imem ();

  always #5 clk = ~clk;

  function automatic logic [15:0] memf(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h0123;
      16'h0001: return 16'h1456;
      16'h0002: return 16'h8210;
      16'h0003: return 16'hC3F0;
      default:  return {a[7:0] ^ 8'h5A, a[7:0]};
    endcase
  endfunction

  assign imem.imem_rdata = ovr ? 16'h1234 : memf(imem.imem_addr);

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (imem.master),
    .hold        (hold),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pcctrl      (pcctrl),
    .if_instr    (if_instr),
    .if_pc_plus1 (if_pc_plus1),
    .if_valid    (if_valid),
    .last_instr  (last_instr),
    .last_pcctrl (last_pcctrl)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch  (perf_fetch),
    .perf_stall  (perf_stall)
`endif
  );

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    rst = v.rst; hold = v.hold; redirect = v.redir; redirect_pc = v.rpc;
    pcctrl = v.pcctrl; ovr = v.ovr;
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_empty step %0d: got 0 want 1", idx);
    end else begin
      e = sb.pop_front();
      chk("imem_addr",   idx, 32'(imem.imem_addr), 32'(e.addr));
      chk("if_instr",    idx, 32'(if_instr),       32'(e.instr));
      chk("if_pc_plus1", idx, 32'(if_pc_plus1),    32'(e.pp1));
      chk("if_valid",    idx, 32'(if_valid),       32'(e.v));
      chk("last_instr",  idx, 32'(last_instr),     32'(e.last));
      chk("last_pcctrl", idx, 32'(last_pcctrl),    32'(e.lpc));
    end
  endtask

  initial begin
    // rst hold redir ovr pcctrl rpc | addr instr pp1 v last lpc
    tbl.push_back('{0,1,1,1,0,16'h1234, 16'h0000,16'h0000,16'h0000,0,16'h0000,0});
    tbl.push_back('{0,1,1,1,1,16'h1234, 16'h0000,16'h0000,16'h0000,0,16'h0000,0});
    tbl.push_back('{1,0,0,0,0,16'h0000, 16'h0001,16'h0123,16'h0001,1,16'h0000,0});
    tbl.push_back('{1,0,0,0,0,16'h0000, 16'h0002,16'h1456,16'h0002,1,16'h0123,0});
    tbl.push_back('{1,0,0,0,0,16'h0000, 16'h0003,16'h8210,16'h0003,1,16'h1456,0});
    tbl.push_back('{1,1,0,0,1,16'h0000, 16'h0003,16'h8210,16'h0003,1,16'h0000,0});
    tbl.push_back('{1,1,0,0,1,16'h0000, 16'h0003,16'h8210,16'h0003,1,16'h0000,0});
    tbl.push_back('{1,1,0,0,1,16'h0000, 16'h0003,16'h8210,16'h0003,1,16'h0000,0});
    tbl.push_back('{1,0,0,0,0,16'h0000, 16'h0004,16'hC3F0,16'h0004,1,16'h8210,0});
    tbl.push_back('{1,0,0,0,1,16'h0000, 16'h0005,16'h5E04,16'h0005,1,16'hC3F0,1});
    tbl.push_back('{1,1,0,0,1,16'h0000, 16'h0005,16'h5E04,16'h0005,1,16'h0000,0});
    tbl.push_back('{1,1,1,0,0,16'h0040, 16'h0040,16'h0000,16'h0005,0,16'h0000,0});
    tbl.push_back('{1,0,0,0,1,16'h0000, 16'h0041,16'h1A40,16'h0041,1,16'h0000,0});
    tbl.push_back('{1,0,0,0,0,16'h0000, 16'h0042,16'h1B41,16'h0042,1,16'h1A40,0});
    tbl.push_back('{1,0,1,0,0,16'hFFFF, 16'hFFFF,16'h0000,16'h0042,0,16'h0000,0});
    tbl.push_back('{1,0,0,0,0,16'h0000, 16'h0000,16'hA5FF,16'h0000,1,16'h0000,0});
    tbl.push_back('{1,0,0,0,0,16'h0000, 16'h0001,16'h0123,16'h0001,1,16'hA5FF,0});
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // back-to-back redirects, redirect to current pc, reset mid-hold
    apply('{1,0,1,0,0,16'h0010, 16'h0010,16'h0000,16'h0001,0,16'h0000,0}, 100);
    apply('{1,0,1,0,0,16'h0020, 16'h0020,16'h0000,16'h0001,0,16'h0000,0}, 101);
    apply('{1,0,0,0,0,16'h0000, 16'h0021,16'h7A20,16'h0021,1,16'h0000,0}, 102);
    apply('{1,0,1,0,0,16'h0021, 16'h0021,16'h0000,16'h0021,0,16'h0000,0}, 103);
    apply('{1,0,0,0,0,16'h0000, 16'h0022,16'h7B21,16'h0022,1,16'h0000,0}, 104);
    apply('{1,1,0,0,1,16'h0000, 16'h0022,16'h7B21,16'h0022,1,16'h0000,0}, 105);
    apply('{0,1,0,0,1,16'h0000, 16'h0000,16'h0000,16'h0000,0,16'h0000,0}, 106);

    // wrap with counters from a fresh reset
    apply('{1,0,1,0,0,16'hFFFF, 16'hFFFF,16'h0000,16'h0000,0,16'h0000,0}, 200);
    apply('{1,0,0,0,0,16'h0000, 16'h0000,16'hA5FF,16'h0000,1,16'h0000,0}, 201);
    apply('{1,0,0,0,0,16'h0000, 16'h0001,16'h0123,16'h0001,1,16'hA5FF,0}, 202);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch", 202, perf_fetch, 32'd2);
    chk("perf_stall", 202, perf_stall, 32'd0);
`endif
    apply('{1,1,0,0,0,16'h0000, 16'h0001,16'h0123,16'h0001,1,16'h0000,0}, 203);
    apply('{1,1,1,0,0,16'h0008, 16'h0008,16'h0000,16'h0001,0,16'h0000,0}, 204);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch", 204, perf_fetch, 32'd2);
    chk("perf_stall", 204, perf_stall, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
